fp_int_mul_sched: RTL

Bit-serial issue controller for the `fp_int_mul` datapath. It accepts (fp16 activation, integer weight word, precision) operations on a valid/ready port and serializes each weight MSB-first into the multiplier's `w` bit stream. It holds `valid`, `act` and `precision` stable for the operation and captures the multiplier's sign/exponent/mantissa into a 2-entry result FIFO. Issue is credit-limited so that no result is ever lost to back-pressure.

---
 rtl/fp_int_mul_sched_if.sv | 53 +++++
 rtl/fp_int_mul_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fp_int_mul_sched_if.sv
// Handshake/bus bundle for fp_int_mul_sched: operation input, multiplier
// drive/capture, result FIFO head and status.
// master: operation source / multiplier / result consumer side.
// slave:  the scheduler itself.
interface fp_int_mul_sched_if #(
  parameter int ACT_WIDTH     = 16,
  parameter int MAX_PRECISION = 8,
  parameter int MANT_WIDTH    = 14
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ACT_WIDTH-1:0]     in_act;
  logic [MAX_PRECISION-1:0] in_w;
  logic [3:0]               in_precision;

  logic                     mul_valid;
  logic [ACT_WIDTH-1:0]     mul_act;
  logic                     mul_w;
  logic [3:0]               mul_precision;
  logic                     mul_start_acc;
  logic                     mul_sign;
  logic [4:0]               mul_exp;
  logic [MANT_WIDTH-1:0]    mul_mant;

  logic                     res_valid;
  logic                     res_ready;
  logic                     res_sign;
  logic [4:0]               res_exp;
  logic [MANT_WIDTH-1:0]    res_mant;

  logic                     busy;
  logic                     err_ovf;

  modport master (
    output in_valid, in_act, in_w, in_precision,
    input  in_ready,
    input  mul_valid, mul_act, mul_w, mul_precision,
    output mul_start_acc, mul_sign, mul_exp, mul_mant,
    input  res_valid, res_sign, res_exp, res_mant,
    output res_ready,
    input  busy, err_ovf
  );

  modport slave (
    input  in_valid, in_act, in_w, in_precision,
    output in_ready,
    output mul_valid, mul_act, mul_w, mul_precision,
    input  mul_start_acc, mul_sign, mul_exp, mul_mant,
    output res_valid, res_sign, res_exp, res_mant,
    input  res_ready,
    output busy, err_ovf
  );
endinterface

// File: rtl/fp_int_mul_sched.sv
// fp_int_mul_sched: bit-serial issue controller for the fp_int_mul datapath.
// Serializes each weight MSB-first onto mul_w, holds act/precision for the
// operation, and captures multiplier results into a 2-entry FWFT FIFO.
// Issue is credit-limited (in flight + queued <= 2) so results never drop.
// Optional feature: define FP_INT_SCHED_ZERO_SKIP_EN to skip all-zero weights
// and push a zero result directly instead of issuing them.
//
// state | meaning
// IDLE  | nothing issuing, mul_valid low
// SHIFT | streaming weight bits; cnt = bits still to send after this one
module fp_int_mul_sched #(
  parameter int ACT_WIDTH     = 16,
  parameter int MAX_PRECISION = 8,
  parameter int MANT_WIDTH    = 14
) (
  input logic                clk,
  input logic                rst,
  fp_int_mul_sched_if.slave  bus
);

`ifdef FP_INT_SCHED_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  localparam logic [3:0] MAXP = 4'(MAX_PRECISION);
  localparam int         RW   = MANT_WIDTH + 6;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state;
  logic [3:0]               cnt;
  logic [MAX_PRECISION-1:0] w_sh;
  logic                     zpend;
  logic [1:0]               outstanding;

  logic [RW-1:0]            mem [2];
  logic                     wr_ptr, rd_ptr;
  logic [1:0]               occ;

  logic [3:0]               p_clamp;
  logic [MAX_PRECISION-1:0] w_mask, w_al;
  logic                     zero_w, last, accept, pop, capture, full, push_ok, drop;
  logic [2:0]               credit_use;
  logic [RW-1:0]            push_data;

  // clamp requested precision into 2..MAX_PRECISION
  always_comb begin
    p_clamp = bus.in_precision;
    if (bus.in_precision < 4'd2)
      p_clamp = 4'd2;
    else if (bus.in_precision > MAXP)
      p_clamp = MAXP;
  end

  // handshake, credit and capture decode
  always_comb begin
    w_mask     = bus.in_w & ~({MAX_PRECISION{1'b1}} << p_clamp);
    w_al       = w_mask << (MAXP - p_clamp);
    zero_w     = ZERO_SKIP && (w_mask == '0);
    last       = (state == SHIFT) && (cnt == 4'd0);
    pop        = (occ != 2'd0) && bus.res_ready;
    credit_use = {1'b0, outstanding} + {1'b0, occ} - {2'b00, pop};
    accept     = bus.in_valid && (state == IDLE || last) && (credit_use < 3'd2);
    // a real multiplier strobe wins; a pending zero result waits one cycle
    capture    = bus.mul_start_acc || zpend;
    push_data  = bus.mul_start_acc ? {bus.mul_sign, bus.mul_exp, bus.mul_mant} : '0;
    full       = (occ == 2'd2);
    push_ok    = capture && (!full || pop);
    drop       = capture && full && !pop;
  end

  assign bus.in_ready  = (state == IDLE || last) && (credit_use < 3'd2);
  assign bus.busy      = (state != IDLE) || (outstanding != 2'd0);
  assign bus.res_valid = (occ != 2'd0);
  assign {bus.res_sign, bus.res_exp, bus.res_mant} = mem[rd_ptr];

  // issue FSM: load on accept, shift MSB-first, reload on last bit if offered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      w_sh              <= '0;
      zpend             <= 1'b0;
      bus.mul_valid     <= 1'b0;
      bus.mul_act       <= '0;
      bus.mul_w         <= 1'b0;
      bus.mul_precision <= 4'd0;
    end else begin
      if (zpend && !bus.mul_start_acc)
        zpend <= 1'b0;
      if (accept && zero_w)
        zpend <= 1'b1;
      if (accept && !zero_w) begin
        state             <= SHIFT;
        cnt               <= p_clamp - 4'd1;
        bus.mul_valid     <= 1'b1;
        bus.mul_act       <= bus.in_act;
        bus.mul_precision <= p_clamp;
        bus.mul_w         <= w_al[MAX_PRECISION-1];
        w_sh              <= w_al << 1;
      end else if (state == SHIFT) begin
        if (last) begin
          state         <= IDLE;
          bus.mul_valid <= 1'b0;
          bus.mul_w     <= 1'b0;
        end else begin
          cnt       <= cnt - 4'd1;
          bus.mul_w <= w_sh[MAX_PRECISION-1];
          w_sh      <= w_sh << 1;
        end
      end
    end
  end

  // credits: operations accepted but whose result is not yet captured
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      outstanding <= 2'd0;
    else
      outstanding <= outstanding + {1'b0, accept} - {1'b0, capture && (outstanding != 2'd0)};
  end

  // 2-entry first-word-fall-through result FIFO with sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      bus.err_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push_ok} - {1'b0, pop};
      if (drop)
        bus.err_ovf <= 1'b1;
    end
  end

endmodule
